// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / divide unit with architectural HI/LO registers.
// One iteration per cycle for 32 cycles, then a single fix-up cycle commits HI/LO.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_a_q, neg_a_d;
    logic        b_zero_q, b_zero_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Operand magnitudes for the start cycle
    logic        op_signed;
    logic        op_is_div;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    // Iteration datapath
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem;

    // Commit datapath
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_comb begin
        op_signed = ~op[0];
        op_is_div = op[1];
        a_mag     = (op_signed && a[31]) ? (32'd0 - a) : a;
        b_mag     = (op_signed && b[31]) ? (32'd0 - b) : b;
    end

    // Multiply: accumulator holds {partial product, remaining multiplier bits}.
    // Divide: accumulator holds {partial remainder, dividend bits / quotient bits}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_shift = {acc_q[63:32], acc_q[31]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_rem   = div_ge ? (div_shift[31:0] - opnd_q) : div_shift[31:0];
    end

    always_comb begin
        prod_fix = acc_q;
        quot_fix = acc_q[31:0];
        rem_fix  = acc_q[63:32];
        if (!op_q[0] && neg_res_q) begin
            prod_fix = 64'd0 - acc_q;
            quot_fix = 32'd0 - acc_q[31:0];
        end
        if (!op_q[0] && neg_a_q) begin
            rem_fix = 32'd0 - acc_q[63:32];
        end
        // The remainder already equals |a|, so giving it a's sign returns a itself
        if (b_zero_q) begin
            quot_fix = 32'hFFFF_FFFF;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_a_d   = neg_a_q;
        b_zero_d  = b_zero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            IDLE: begin
                if (mthi || mtlo) begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end else if (start) begin
                    state_d   = RUN;
                    cnt_d     = 5'd0;
                    op_d      = op;
                    busy_d    = 1'b1;
                    neg_res_d = a[31] ^ b[31];
                    neg_a_d   = a[31];
                    b_zero_d  = op_is_div && (b == 32'd0);
                    if (op_is_div) begin
                        opnd_d = b_mag;
                        acc_d  = {32'd0, a_mag};
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {32'd0, b_mag};
                    end
                end
            end
            RUN: begin
                if (op_q[1]) begin
                    acc_d = {div_rem, acc_q[30:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (op_q == OP_DIV || op_q == OP_DIVU) begin
                    lo_d = quot_fix;
                    hi_d = rem_fix;
                end else if (op_q == OP_MULT || op_q == OP_MULTU) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            op_q      <= 2'd0;
            opnd_q    <= 32'd0;
            acc_q     <= 64'd0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            b_zero_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_a_q   <= neg_a_d;
            b_zero_q  <= b_zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, handshake timing,
// strobe interaction and mid-operation reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mt(input logic wh, input logic wl, input logic [31:0] d);
        @(negedge clk);
        mthi = wh; mtlo = wl; wdata = d;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [31:0] ehi, input logic [31:0] elo,
                          input bit inject);
        int bc;
        int dc;
        int extra;
        logic [31:0] hi0;
        logic [31:0] lo0;
        bc = 0; dc = 0; extra = 0;
        hi0 = hi; lo0 = lo;
        @(negedge clk);
        op = o; a = ia; b = ib; start = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            if (busy) bc++;
            if (done) begin
                dc++;
                break;
            end
            if (bc == 16) begin
                chk({tag, " hi held"}, {32'd0, hi}, {32'd0, hi0});
                chk({tag, " lo held"}, {32'd0, lo}, {32'd0, lo0});
            end
            if (inject && bc == 5) begin
                start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
                wdata = 32'hDEAD_BEEF; a = 32'd1000; b = 32'd1000;
            end
        end
        chk({tag, " done seen"}, 64'(dc), 64'd1);
        chk({tag, " busy cycles"}, 64'(bc), 64'd33);
        chk({tag, " busy at done"}, {63'd0, busy}, 64'd0);
        chk({tag, " hi"}, {32'd0, hi}, {32'd0, ehi});
        chk({tag, " lo"}, {32'd0, lo}, {32'd0, elo});
        $display("op %s: hi=%h lo=%h busy_cycles=%0d", tag, hi, lo, bc);
        @(negedge clk);
        chk({tag, " done width"}, {63'd0, done}, 64'd0);
        if (inject) begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done || busy) extra++;
            end
            chk({tag, " no restart"}, 64'(extra), 64'd0);
            chk({tag, " hi after"}, {32'd0, hi}, {32'd0, ehi});
            chk({tag, " lo after"}, {32'd0, lo}, {32'd0, elo});
        end
    endtask

    initial begin
        int bc;
        int extra;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset hi", {32'd0, hi}, 64'd0);
        chk("reset lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;

        run_op("MULTU max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("MULT -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("MULT 5*-4", 2'b00, 32'd5, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 0);
        run_op("MULT min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
        run_op("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("DIV 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
        run_op("DIVU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run_op("DIVU by 0", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 0);
        run_op("DIV -7/0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
        run_op("DIV min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);

        // Direct writes, alone, together, and winning over a simultaneous start
        mt(1'b1, 1'b0, 32'h1357_9BDF);
        chk("mthi hi", {32'd0, hi}, {32'd0, 32'h1357_9BDF});
        chk("mthi lo kept", {32'd0, lo}, {32'd0, 32'h8000_0000});
        mt(1'b1, 1'b1, 32'h2468_ACE0);
        chk("mt both hi", {32'd0, hi}, {32'd0, 32'h2468_ACE0});
        chk("mt both lo", {32'd0, lo}, {32'd0, 32'h2468_ACE0});
        @(negedge clk);
        start = 1'b1; mtlo = 1'b1; wdata = 32'h0BAD_F00D; op = 2'b01; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        chk("mt+start busy", {63'd0, busy}, 64'd0);
        chk("mt+start lo", {32'd0, lo}, {32'd0, 32'h0BAD_F00D});

        mt(1'b1, 1'b0, 32'hA5A5_A5A5);
        chk("mthi A5", {32'd0, hi}, {32'd0, 32'hA5A5_A5A5});
        run_op("MULTU 3*4 inject", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1);

        // Reset at RUN counter 10
        mt(1'b1, 1'b0, 32'h1111_1111);
        bc = 0;
        @(negedge clk);
        op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bc++;
            if (bc == 11) break;
        end
        chk("pre-reset busy cycles", 64'(bc), 64'd11);
        rst = 1'b1;
        #1;
        chk("async rst busy", {63'd0, busy}, 64'd0);
        chk("async rst hi", {32'd0, hi}, 64'd0);
        chk("async rst lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk("post-reset quiet", 64'(extra), 64'd0);
        chk("post-reset hi", {32'd0, hi}, 64'd0);
        chk("post-reset lo", {32'd0, lo}, 64'd0);
        run_op("MULTU 9*9 after rst", 2'b01, 32'd9, 32'd9, 32'd0, 32'd81, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have the port `clk`, an input of 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port `rst`, an input of 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have the port `start`, an input of 1 bit: request a multiply/divide, sampled in IDLE only.
REQ-004 The block SHALL have the port `op`, an input of 2 bits: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-005 The block SHALL have the port `a`, an input of 32 bits: multiplicand or dividend.
REQ-006 The block SHALL have the port `b`, an input of 32 bits: multiplier or divisor.
REQ-007 The block SHALL have the ports `mthi` and `mtlo`, inputs of 1 bit each: direct-write strobes for HI and LO.
REQ-008 The block SHALL have the port `wdata`, an input of 32 bits: data for `mthi` and `mtlo`.
REQ-009 The block SHALL have the port `busy`, an output of 1 bit: an operation is in progress.
REQ-010 The block SHALL have the port `done`, an output of 1 bit: a one-cycle pulse marking that the result has been committed.
REQ-011 The block SHALL have the ports `hi` and `lo`, outputs of 32 bits each: the architectural HI/LO registers, fed to the writeback 4-to-1 result select (ctr=10 HI, ctr=11 LO).

Function
REQ-012 The block SHALL implement exactly the states IDLE, RUN and FIN.
REQ-013 In IDLE with `start`=1 and `mthi`=`mtlo`=0, the block SHALL, at the next edge, latch `op` and the operand magnitudes (absolute values for signed ops, raw for unsigned), record the result signs, clear the iteration counter to 0, set `busy`=1 and enter RUN.
REQ-014 RUN SHALL perform one iteration per cycle for exactly 32 cycles (counter 0..31), then enter FIN.
REQ-015 Multiply SHALL use a shift-add over a 64-bit accumulator on the magnitudes.
REQ-016 Divide SHALL use a restoring shift-subtract yielding a 32-bit quotient and a 32-bit remainder on the magnitudes.
REQ-017 FIN SHALL, in one cycle, apply the sign correction and write HI/LO.
REQ-018 The sign correction SHALL negate the product when sign(a) XOR sign(b), negate the quotient on the same condition, and give the remainder the sign of a (signed ops only).
REQ-019 FIN SHALL write multiply results as HI = product[63:32] and LO = product[31:0].
REQ-020 FIN SHALL write divide results as LO = quotient and HI = remainder.
REQ-021 At the FIN edge the block SHALL set `busy`=0, set `done`=1 for exactly one cycle and return to IDLE.
REQ-022 `busy` SHALL be high for exactly 33 consecutive cycles per accepted start.
REQ-023 New HI/LO values SHALL be visible in the same cycle that `done`=1.
REQ-024 `hi` and `lo` SHALL retain their old values throughout RUN; intermediate values SHALL NOT be exposed.
REQ-025 The block SHALL ignore `start` while `busy`=1; it SHALL neither queue nor restart the request.
REQ-026 In IDLE, `mthi` SHALL load HI with `wdata` and `mtlo` SHALL load LO with `wdata`; both may assert in the same cycle.
REQ-027 If `mthi` or `mtlo` asserts in the same cycle as `start`, the block SHALL perform the write and ignore `start`.
REQ-028 The block SHALL ignore `mthi` and `mtlo` while `busy`=1.
REQ-029 For divide by zero, the block SHALL run the normal 33-cycle sequence and produce LO=0xFFFFFFFF and HI=a, with no sign correction applied.
REQ-030 For DIV of 0x80000000 by 0xFFFFFFFF, the block SHALL produce LO=0x80000000 and HI=0 (natural wrap, no trap).
REQ-031 All arithmetic SHALL be modulo 2^32 per register; there SHALL be no overflow flags.

Reset
REQ-032 While `rst`=1, the block SHALL force the state to IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0 and clear the counter and accumulators, asynchronously.
REQ-033 A reset mid-RUN or in FIN SHALL abort the operation with no HI/LO commit and no `done` pulse.
REQ-034 After `rst` deasserts, the first `start` SHALL be accepted on the first rising edge.

Verification
REQ-035 The bench SHALL apply MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF and check HI=0xFFFFFFFE, LO=0x00000001, with `busy` high for 33 cycles and a single-cycle `done`.
REQ-036 The bench SHALL apply MULT with a=0xFFFFFFFD (-3), b=7 and check HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
REQ-037 The bench SHALL apply DIV with a=-7 (0xFFFFFFF9), b=2 and check LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); it SHALL also apply DIVU with a=100, b=7 and check LO=14, HI=2.
REQ-038 The bench SHALL apply DIVU with a=0x12345678, b=0 and check LO=0xFFFFFFFF, HI=0x12345678.
REQ-039 The bench SHALL load `mthi` with wdata=0xA5A5A5A5, start MULTU 3*4, pulse `start` and `mtlo` mid-RUN, and check that both strobes are ignored, that exactly one `done` occurs, and that HI=0, LO=12.
REQ-040 The bench SHALL assert `rst` at RUN counter 10 and check that `busy`=0, `hi`=`lo`=0 and no `done` occur; a subsequent start SHALL then complete normally.
